// File: rtl/uc_pilha_param_if.sv
// uc_pilha_param_if
// Bundles the control unit's buses toward ROM, RAM, stack, temp registers
// and ULA.
//   master : the control unit (uc_pilha_param)
//   slave  : the datapath side (ROM, RAM, stack, temp1/temp2, ULA)
// Signals:
//   inst           ROM word {opcode, addr}, valid 1 cycle after a_rom
//   data_mem       RAM read data, sampled at the end of LE_RAM
//   controle_ula   ULA compare result (1 = equal)
//   a_rom          program counter
//   a_ram          RAM address
//   ram_wren       RAM write strobe (datapath writes temp1)
//   push / pop     stack strobes
//   controle_pilha stack input mux (0 = data_pilha, 1 = ULA result)
//   data_pilha     stack write data when controle_pilha = 0
//   load_temp1/2   temp register loads from stack top
//   opcode         decoded opcode to ULA
//   halt / erro    core stopped / sticky trap flag
interface uc_pilha_param_if #(
    parameter int DATAW = 16,
    parameter int ADDRW = 5,
    parameter int OPW   = 5
);
    logic [OPW+ADDRW-1:0] inst;
    logic [DATAW-1:0]     data_mem;
    logic                 controle_ula;
    logic [ADDRW-1:0]     a_rom;
    logic [ADDRW-1:0]     a_ram;
    logic                 ram_wren;
    logic                 push;
    logic                 pop;
    logic                 controle_pilha;
    logic [DATAW-1:0]     data_pilha;
    logic                 load_temp1;
    logic                 load_temp2;
    logic [OPW-1:0]       opcode;
    logic                 halt;
    logic                 erro;

    modport master (
        input  inst, data_mem, controle_ula,
        output a_rom, a_ram, ram_wren, push, pop, controle_pilha,
               data_pilha, load_temp1, load_temp2, opcode, halt, erro
    );

    modport slave (
        output inst, data_mem, controle_ula,
        input  a_rom, a_ram, ram_wren, push, pop, controle_pilha,
               data_pilha, load_temp1, load_temp2, opcode, halt, erro
    );
endinterface

// File: rtl/uc_pilha_param.sv
// uc_pilha_param
// Parametrised control unit of the stack processor. Fetches from a
// synchronous ROM, sequences stack/RAM/temp/ULA strobes through an FSM,
// tracks the stack pointer and traps on overflow, underflow and illegal
// opcodes. HALT parks the core until reset.
// Ports:
//   clock  system clock, rising edge
//   reset  synchronous, active-low
//   bus    uc_pilha_param_if.master (ROM, RAM, stack, temp, ULA signals)
// All bus outputs are registers; no input reaches an output combinationally.
module uc_pilha_param #(
    parameter int DATAW = 16,
    parameter int ADDRW = 5,
    parameter int OPW   = 5,
    parameter int DEPTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    uc_pilha_param_if.master bus
);

    localparam int IW  = OPW + ADDRW;
    localparam int SPW = $clog2(DEPTH + 1);

    localparam logic [3:0] BUSCA   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] LE_RAM  = 4'd2;
    localparam logic [3:0] EMPILHA = 4'd3;
    localparam logic [3:0] DESEMP1 = 4'd4;
    localparam logic [3:0] DESEMP2 = 4'd5;
    localparam logic [3:0] ESCREVE = 4'd6;
    localparam logic [3:0] ULA     = 4'd7;
    localparam logic [3:0] DECIDE  = 4'd8;
    localparam logic [3:0] PARADO  = 4'd9;
    localparam logic [3:0] ERRO    = 4'd10;

    localparam logic [4:0] OP_NOP    = 5'd0;
    localparam logic [4:0] OP_PUSH_M = 5'd1;
    localparam logic [4:0] OP_PUSH_I = 5'd2;
    localparam logic [4:0] OP_POP_M  = 5'd3;
    localparam logic [4:0] OP_GOTO   = 5'd13;
    localparam logic [4:0] OP_IF_EQ  = 5'd14;
    localparam logic [4:0] OP_HALT   = 5'd15;

    logic [3:0]       state_q, state_d;
    logic [ADDRW-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic [IW-1:0]    ir_q, ir_d;
    logic [ADDRW-1:0] a_ram_q, a_ram_d;
    logic [OPW-1:0]   opcode_q, opcode_d;
    logic [DATAW-1:0] data_pilha_q, data_pilha_d;
    logic             push_q, push_d;
    logic             pop_q, pop_d;
    logic             ctrl_pilha_q, ctrl_pilha_d;
    logic             ram_wren_q, ram_wren_d;
    logic             lt1_q, lt1_d;
    logic             lt2_q, lt2_d;
    logic             halt_q, halt_d;
    logic             erro_q, erro_d;

    // Fields of the ROM word being decoded (valid during DECODE) and of IR.
    logic [OPW-1:0]   dec_op;
    logic [4:0]       dec_lo;
    logic [ADDRW-1:0] dec_addr;
    logic             dec_hi;
    logic [4:0]       ir_lo;
    logic [ADDRW-1:0] ir_addr;

    logic dec_is_push, dec_is_alu, trap;

    assign dec_op   = bus.inst[IW-1:ADDRW];
    assign dec_lo   = dec_op[4:0];
    assign dec_addr = bus.inst[ADDRW-1:0];
    assign ir_lo    = ir_q[ADDRW+4:ADDRW];
    assign ir_addr  = ir_q[ADDRW-1:0];

    // Any opcode bit above bit 4 makes the instruction illegal.
    always_comb begin
        dec_hi = 1'b0;
        for (int unsigned i = 5; i < OPW; i++) begin
            dec_hi = dec_hi | dec_op[i];
        end
    end

    assign dec_is_push = (dec_lo == OP_PUSH_M) || (dec_lo == OP_PUSH_I);
    assign dec_is_alu  = (dec_lo >= 5'd4) && (dec_lo <= 5'd12);

    // Trap decision is taken in DECODE so no strobe of the trapping
    // instruction is ever issued. A ULA op at sp == DEPTH is legal since it
    // pops twice before pushing.
    assign trap = dec_hi || (dec_lo >= 5'd16)
               || (dec_is_push && (sp_q == SPW'(DEPTH)))
               || ((dec_lo == OP_POP_M) && (sp_q == '0))
               || ((dec_is_alu || (dec_lo == OP_IF_EQ)) && (sp_q < SPW'(2)));

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        ir_d         = ir_q;
        a_ram_d      = a_ram_q;
        opcode_d     = opcode_q;
        data_pilha_d = data_pilha_q;
        push_d       = 1'b0;
        pop_d        = 1'b0;
        ctrl_pilha_d = 1'b0;
        ram_wren_d   = 1'b0;
        lt1_d        = 1'b0;
        lt2_d        = 1'b0;
        halt_d       = halt_q;
        erro_d       = erro_q;

        // Strobes are registered, so each is raised on the transition into
        // the state in which it must be seen.
        case (state_q)
            BUSCA: state_d = DECODE;
            DECODE: begin
                ir_d     = bus.inst;
                opcode_d = dec_op;
                if (trap) begin
                    state_d = ERRO;
                    erro_d  = 1'b1;
                    halt_d  = 1'b1;
                end else begin
                    case (dec_lo)
                        OP_NOP: begin
                            pc_d    = pc_q + ADDRW'(1);
                            state_d = BUSCA;
                        end
                        OP_PUSH_M: begin
                            a_ram_d = dec_addr;
                            state_d = LE_RAM;
                        end
                        OP_PUSH_I: begin
                            data_pilha_d = DATAW'(dec_addr);
                            push_d       = 1'b1;
                            state_d      = EMPILHA;
                        end
                        OP_GOTO: begin
                            pc_d    = dec_addr;
                            state_d = BUSCA;
                        end
                        OP_HALT: begin
                            halt_d  = 1'b1;
                            state_d = PARADO;
                        end
                        // POP_M, ULA ops and IF_EQ all start with a pop into temp1.
                        default: begin
                            pop_d   = 1'b1;
                            lt1_d   = 1'b1;
                            state_d = DESEMP1;
                        end
                    endcase
                end
            end
            LE_RAM: begin
                data_pilha_d = bus.data_mem;
                push_d       = 1'b1;
                state_d      = EMPILHA;
            end
            EMPILHA: begin
                pc_d    = pc_q + ADDRW'(1);
                state_d = BUSCA;
            end
            DESEMP1: begin
                if (ir_lo == OP_POP_M) begin
                    ram_wren_d = 1'b1;
                    a_ram_d    = ir_addr;
                    state_d    = ESCREVE;
                end else begin
                    pop_d   = 1'b1;
                    lt2_d   = 1'b1;
                    state_d = DESEMP2;
                end
            end
            DESEMP2: state_d = ULA;
            ULA: begin
                if (ir_lo == OP_IF_EQ) begin
                    state_d = DECIDE;
                end else begin
                    push_d       = 1'b1;
                    ctrl_pilha_d = 1'b1;
                    state_d      = EMPILHA;
                end
            end
            DECIDE: begin
                pc_d    = bus.controle_ula ? ir_addr : pc_q + ADDRW'(1);
                state_d = BUSCA;
            end
            ESCREVE: begin
                pc_d    = pc_q + ADDRW'(1);
                state_d = BUSCA;
            end
            PARADO:  state_d = PARADO;
            ERRO:    state_d = ERRO;
            default: state_d = BUSCA;
        endcase

        if (push_d) begin
            sp_d = sp_q + SPW'(1);
        end else if (pop_d) begin
            sp_d = sp_q - SPW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q      <= BUSCA;
            pc_q         <= '0;
            sp_q         <= '0;
            ir_q         <= '0;
            a_ram_q      <= '0;
            opcode_q     <= '0;
            data_pilha_q <= '0;
            push_q       <= 1'b0;
            pop_q        <= 1'b0;
            ctrl_pilha_q <= 1'b0;
            ram_wren_q   <= 1'b0;
            lt1_q        <= 1'b0;
            lt2_q        <= 1'b0;
            halt_q       <= 1'b0;
            erro_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            ir_q         <= ir_d;
            a_ram_q      <= a_ram_d;
            opcode_q     <= opcode_d;
            data_pilha_q <= data_pilha_d;
            push_q       <= push_d;
            pop_q        <= pop_d;
            ctrl_pilha_q <= ctrl_pilha_d;
            ram_wren_q   <= ram_wren_d;
            lt1_q        <= lt1_d;
            lt2_q        <= lt2_d;
            halt_q       <= halt_d;
            erro_q       <= erro_d;
        end
    end

    assign bus.a_rom          = pc_q;
    assign bus.a_ram          = a_ram_q;
    assign bus.ram_wren       = ram_wren_q;
    assign bus.push           = push_q;
    assign bus.pop            = pop_q;
    assign bus.controle_pilha = ctrl_pilha_q;
    assign bus.data_pilha     = data_pilha_q;
    assign bus.load_temp1     = lt1_q;
    assign bus.load_temp2     = lt2_q;
    assign bus.opcode         = opcode_q;
    assign bus.halt           = halt_q;
    assign bus.erro           = erro_q;

endmodule
